// File: rtl/filt_stim_gen.sv
// Burst stimulus generator (step / ramp / square / noisy square) feeding the 4-tap smoothing filter.
// Define STIM_NOISE_EN to build the noise LFSR; otherwise mode 3 falls back to the plain square wave.
module filt_stim_gen #(
    parameter int         NUM_SAMPLES = 64,
    parameter int         HALF_PERIOD = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] amplitude,
    input  logic       hold,
    output logic [7:0] x,
    output logic       x_valid,
    output logic       busy,
    output logic       done
);

    localparam int             KW      = $clog2(NUM_SAMPLES + 1);
    localparam logic [KW-1:0]  KEnd    = KW'(NUM_SAMPLES);
    localparam logic [KW-1:0]  KHalf   = KW'(NUM_SAMPLES / 2);
    localparam logic [7:0]     PhLast  = 8'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic [7:0]    phase_q;
    logic          oddHalf_q;
    logic [1:0]    mode_q;
    logic [7:0]    amp_q;
    logic [7:0]    x_q;
    logic          xValid_q;
    logic          busy_q;
    logic          done_q;

    logic [1:0]    curMode;
    logic [7:0]    curAmp;
    logic [7:0]    sqVal;
    logic [7:0]    noisyVal;
    logic [7:0]    sample_d;
    logic [7:0]    phase_d;
    logic          oddHalf_d;
    logic          emit;

`ifdef STIM_NOISE_EN
    localparam logic [7:0] SeedEff = (LFSR_SEED == 8'd0) ? 8'h01 : LFSR_SEED;
    logic [7:0] lfsr_q;
    logic [8:0] noisySum;
`endif

    // In IDLE the first sample is built straight from the inputs, since mode/amplitude latch on the same edge.
    always_comb begin
        curMode   = (state_q == IDLE) ? mode : mode_q;
        curAmp    = (state_q == IDLE) ? amplitude : amp_q;
        sqVal     = oddHalf_q ? curAmp : 8'd0;
        noisyVal  = sqVal;
`ifdef STIM_NOISE_EN
        noisySum  = {1'b0, sqVal} + {6'd0, lfsr_q[2:0]};
        noisyVal  = noisySum[8] ? 8'hFF : noisySum[7:0];
`endif
        case (curMode)
            2'd0:    sample_d = (k_q < KHalf) ? 8'd0 : curAmp;
            2'd1:    sample_d = curAmp + 8'(k_q);
            2'd2:    sample_d = sqVal;
            default: sample_d = noisyVal;
        endcase
        if (phase_q == PhLast) begin
            phase_d   = 8'd0;
            oddHalf_d = ~oddHalf_q;
        end else begin
            phase_d   = phase_q + 8'd1;
            oddHalf_d = oddHalf_q;
        end
        emit = ((state_q == IDLE) && start) ||
               ((state_q == RUN) && !hold && (k_q != KEnd));
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            phase_q   <= 8'd0;
            oddHalf_q <= 1'b0;
            mode_q    <= 2'd0;
            amp_q     <= 8'd0;
            x_q       <= 8'd0;
            xValid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q   <= 1'b0;
                    xValid_q <= 1'b0;
                    if (start) begin
                        mode_q    <= mode;
                        amp_q     <= amplitude;
                        x_q       <= sample_d;
                        xValid_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        k_q       <= k_q + 1'b1;
                        phase_q   <= phase_d;
                        oddHalf_q <= oddHalf_d;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (hold) begin
                        xValid_q <= 1'b0;
                    end else if (k_q == KEnd) begin
                        x_q       <= 8'd0;
                        xValid_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        k_q       <= '0;
                        phase_q   <= 8'd0;
                        oddHalf_q <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        x_q       <= sample_d;
                        xValid_q  <= 1'b1;
                        k_q       <= k_q + 1'b1;
                        phase_q   <= phase_d;
                        oddHalf_q <= oddHalf_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef STIM_NOISE_EN
    // The LFSR deliberately survives between bursts; only reset reseeds it.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SeedEff;
        end else if (emit && (curMode == 2'd3)) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
`endif

    assign x       = x_q;
    assign x_valid = xValid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_filt_stim_gen.sv
// Self-checking bench for filt_stim_gen: table-driven bursts plus hand-written hold/reset/start corner cases.
// Expected samples go into a scoreboard queue and are popped whenever the DUT flags x_valid.
module tb_filt_stim_gen;

    localparam int NS = 8;
    localparam int HP = 2;

    logic       CLOCK_50 = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] amplitude = 8'd0;
    logic       hold = 1'b0;
    logic [7:0] x;
    logic       x_valid;
    logic       busy;
    logic       done;

    int         total = 0;
    int         bad = 0;
    int         validCount = 0;
    logic [7:0] sbQ[$];
    logic [7:0] expX;
    logic [7:0] tbLfsr = 8'h01;

    typedef struct {
        logic [1:0]            mode;
        logic [7:0]            amp;
        logic [0:NS-1][7:0]    expX;
    } vec_t;

    vec_t vecs[3];

    filt_stim_gen #(
        .NUM_SAMPLES(NS),
        .HALF_PERIOD(HP),
        .LFSR_SEED(8'h01)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst(rst),
        .start(start),
        .mode(mode),
        .amplitude(amplitude),
        .hold(hold),
        .x(x),
        .x_valid(x_valid),
        .busy(busy),
        .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    // Scoreboard consumer: every valid sample must match the oldest pending expectation.
    always @(posedge CLOCK_50) begin
        #1;
        if (x_valid) begin
            validCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_sample", 1, 0);
            end else begin
                expX = sbQ.pop_front();
                checkOutput("sample_x", int'(x), int'(expX));
                checkOutput("busy_with_valid", int'(busy), 1);
            end
        end
    end

    // Reference model for square / noisy square; the noise part follows the build macro.
    function automatic logic [7:0] modelSquare(input logic [7:0] a, input int k, input bit noisy);
        logic [7:0] sq;
        int         sum;
        sq = (((k / HP) % 2) == 1) ? a : 8'd0;
`ifdef STIM_NOISE_EN
        if (noisy) begin
            sum    = int'(sq) + int'(tbLfsr[2:0]);
            tbLfsr = {tbLfsr[6:0], tbLfsr[7] ^ tbLfsr[5] ^ tbLfsr[4] ^ tbLfsr[3]};
            return (sum > 255) ? 8'd255 : 8'(sum);
        end
`endif
        return sq;
    endfunction

    task automatic pushTable(input logic [0:NS-1][7:0] e);
        for (int j = 0; j < NS; j++) sbQ.push_back(e[j]);
    endtask

    task automatic pushNoisy(input logic [7:0] a);
        for (int j = 0; j < NS; j++) sbQ.push_back(modelSquare(a, j, 1'b1));
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] a);
        @(negedge CLOCK_50);
        validCount = 0;
        mode       = m;
        amplitude  = a;
        start      = 1'b1;
        @(negedge CLOCK_50);
        start      = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int wantValid);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, int'(seen), 1);
        if (seen) begin
            checkOutput({tag, "_done_x"}, int'(x), 0);
            checkOutput({tag, "_done_valid"}, int'(x_valid), 0);
            checkOutput({tag, "_done_busy"}, int'(busy), 0);
            checkOutput({tag, "_queue_left"}, sbQ.size(), 0);
            @(posedge CLOCK_50);
            #1;
            checkOutput({tag, "_done_pulse"}, int'(done), 0);
            checkOutput({tag, "_idle_busy"}, int'(busy), 0);
            checkOutput({tag, "_valid_count"}, validCount, wantValid);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{mode: 2'd0, amp: 8'd200,
                    expX: {8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd200, 8'd200, 8'd200}};
        vecs[1] = '{mode: 2'd1, amp: 8'd250,
                    expX: {8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1}};
        vecs[2] = '{mode: 2'd2, amp: 8'd100,
                    expX: {8'd0, 8'd0, 8'd100, 8'd100, 8'd0, 8'd0, 8'd100, 8'd100}};

        // Reset held with the clock running.
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("reset_x", int'(x), 0);
        checkOutput("reset_valid", int'(x_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        tbLfsr = 8'h01;
        @(negedge CLOCK_50);
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            pushTable(vecs[i].expX);
            applyStimulus(vecs[i].mode, vecs[i].amp);
            waitDone("table", NS);
        end

        // Square with a 3-cycle hold after the third sample.
        pushTable(vecs[2].expX);
        applyStimulus(2'd2, 8'd100);
        repeat (2) @(negedge CLOCK_50);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLOCK_50);
            #1;
            checkOutput("hold_valid", int'(x_valid), 0);
            checkOutput("hold_x", int'(x), 100);
            checkOutput("hold_busy", int'(busy), 1);
        end
        @(negedge CLOCK_50);
        hold = 1'b0;
        waitDone("hold_square", NS);

        // Hold on the last sample delays the DONE transition.
        pushTable({8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17});
        applyStimulus(2'd1, 8'd10);
        repeat (7) @(negedge CLOCK_50);
        hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge CLOCK_50);
            #1;
            checkOutput("holdlast_done", int'(done), 0);
            checkOutput("holdlast_busy", int'(busy), 1);
            checkOutput("holdlast_x", int'(x), 17);
        end
        @(negedge CLOCK_50);
        hold = 1'b0;
        waitDone("hold_last", NS);

        // Two noisy bursts so the LFSR carries across bursts.
        for (int b = 0; b < 2; b++) begin
            pushNoisy(8'd254);
            applyStimulus(2'd3, 8'd254);
            waitDone("noisy", NS);
        end

        // Start held high: no restart in RUN/DONE, fresh burst on the first IDLE edge.
        pushTable(vecs[0].expX);
        pushTable(vecs[0].expX);
        @(negedge CLOCK_50);
        validCount = 0;
        mode       = 2'd0;
        amplitude  = 8'd200;
        start      = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(posedge CLOCK_50);
                #1;
                if (done) seen = 1'b1;
            end
            checkOutput("held_first_done", int'(seen), 1);
        end
        @(posedge CLOCK_50);
        #1;
        checkOutput("held_idle_valid", int'(x_valid), 0);
        checkOutput("held_idle_busy", int'(busy), 0);
        @(posedge CLOCK_50);
        #1;
        checkOutput("held_restart_valid", int'(x_valid), 1);
        checkOutput("held_restart_busy", int'(busy), 1);
        @(negedge CLOCK_50);
        start = 1'b0;
        waitDone("held_start", 2 * NS);

        // Asynchronous reset in the middle of a burst.
        pushTable(vecs[0].expX);
        applyStimulus(2'd0, 8'd200);
        repeat (2) @(negedge CLOCK_50);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_x", int'(x), 0);
        checkOutput("async_valid", int'(x_valid), 0);
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_done", int'(done), 0);
        sbQ.delete();
        tbLfsr = 8'h01;
        @(negedge CLOCK_50);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLOCK_50);
            #1;
            checkOutput("post_reset_valid", int'(x_valid), 0);
            checkOutput("post_reset_busy", int'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filt_stim_gen.md
# filt_stim_gen

Stimulus generator that drives the 8-bit sample stream consumed by the 4-tap moving-average smoothing filter on the lab board. On a `start` pulse it emits a fixed-length burst of `NUM_SAMPLES` samples, one per clock, in one of four waveform modes: step, ramp, square, or noisy square. Bench and on-board exercise of the filter's smoothing response uses this block. It sits directly upstream of the filter's `x` input and shares its clock.

## Interface
- `NUM_SAMPLES`, default 64: samples per burst, range 2..255.
- `HALF_PERIOD`, default 8: samples per half-cycle in square modes, range 1..128.
- `LFSR_SEED`, default 8'hA5: noise LFSR reset value; a value of 0 is replaced by 8'h01.
- `CLOCK_50`  in  1: the only clock, rising edge.
- `rst`  in  1: asynchronous reset, active-low.
- `start`  in  1: begin a burst; sampled in IDLE only.
- `mode`  in  2: 0 step, 1 ramp, 2 square, 3 noisy square; latched at start.
- `amplitude`  in  8: waveform amplitude or ramp base; latched at start.
- `hold`  in  1: pause the burst while high.
- `x`  out  8: sample to filter, registered.
- `x_valid`  out  1: `x` is a new sample this cycle.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse after the last sample.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset (`rst`=0, asynchronous): state IDLE, `x`=0, `x_valid`=0, `busy`=0, `done`=0. Sample index k=0, phase counter=0, LFSR=`LFSR_SEED`.
- IDLE: `start`=1 at an edge latches `mode` and `amplitude`, enters RUN, and emits sample k=0 at that same edge.
- RUN, `hold`=0: each edge emits sample k with `x_valid`=1, then k advances by 1.
- RUN, `hold`=1: `x_valid`=0 and `x` keeps its last value. k, the phase counter and the LFSR all freeze.
- After sample NUM_SAMPLES-1 is emitted, the next non-held edge enters DONE: `x`=0, `x_valid`=0, `busy`=0, `done`=1.
- DONE returns to IDLE on the next edge with `done`=0.
- `start` is ignored in RUN and in DONE. It is level-sampled, so holding it high re-triggers a new burst from IDLE.
- Sample for index k:
  - step: 0 for k < NUM_SAMPLES/2 (integer division), otherwise the latched amplitude A.
  - ramp: (A + k) mod 256, using 8-bit wrap.
  - square: sq = A when floor(k/HALF_PERIOD) is odd, otherwise 0. The phase counter wraps at HALF_PERIOD.
  - noisy square: min(255, sq + lfsr[2:0]), a saturating 9-bit add.
- LFSR: 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1, shifting left. The new bit 0 is b7^b5^b4^b3. It advances once per emitted noisy sample; the current value is used before the shift.
- The k counter is $clog2(NUM_SAMPLES+1) bits wide. The LFSR is not reset between bursts.

## Timing
- `start` to first valid sample: the same edge, so `x_valid` is high in the cycle following the `start` sample.
- A burst without hold takes NUM_SAMPLES cycles of `x_valid`, followed by one cycle of `done`.
- `busy` is high exactly while the state is RUN, including held cycles.
- Reset asserted mid-burst clears all outputs immediately, without waiting for a clock. After release the block stays in IDLE until a new `start`.
- `hold` together with the last sample: the transition to DONE waits until `hold` falls.

## Configuration
- `STIM_NOISE_EN` defined: the LFSR and saturating adder are compiled in, and mode 3 behaves as specified above.
- Not defined: no LFSR is built, and mode 3 produces exactly the square waveform. The `LFSR_SEED` parameter is accepted but unused.

## Test plan
- Reset: with `rst`=0 and a clock running, `x`=0, `x_valid`=0, `busy`=0, `done`=0. Pulling `rst` low mid-burst (after 3 samples) zeroes outputs without a clock edge, and no burst follows until `start`.
- Step, NUM_SAMPLES=8, A=200: `x`=0,0,0,0,200,200,200,200 with `x_valid` high for 8 cycles. Then `done`=1 for one cycle with `x`=0, and `busy` falls.
- Ramp, A=250, NUM_SAMPLES=8: `x`=250,251,252,253,254,255,0,1, checking the 8-bit wrap.
- Square, A=100, HALF_PERIOD=2, NUM_SAMPLES=8:
  - `x`=0,0,100,100,0,0,100,100.
  - With `hold`=1 for 3 cycles after the third sample, `x_valid`=0 for 3 cycles with `x`=100 held, then 100,0,0,100,100 resume.
- Noisy square, A=254, `STIM_NOISE_EN` defined, seed 8'h01: each `x` equals min(255, sq + lfsr[2:0]) against a bench model, and 255 is never exceeded. With the macro undefined, the output is identical to the square test.
- `start` held high through a burst: no restart during RUN or DONE, and a new burst begins on the first IDLE edge.
